// File: rtl/param_pkg.sv
// System-wide cache line geometry that the memory-side blocks share.
package param_pkg;
  localparam int BYTES_PER_LINE   = 16;
  localparam int MAIN_MEM_LINE_AW = 10;
endpackage

// File: rtl/main_mem_ctrl_if.sv
// Line-granular request bus between the main-memory arbiter and the controller,
// plus the controller's strobe-style memory port.
interface main_mem_ctrl_if #(
  parameter int LW = param_pkg::BYTES_PER_LINE * 8,
  parameter int AW = param_pkg::MAIN_MEM_LINE_AW
);
  logic          wcyc_i;
  logic          rcyc_i;
  logic [AW-1:0] waddr_i;
  logic [AW-1:0] raddr_i;
  logic [LW-1:0] wdata_i;
  logic          ack_o;
  logic [LW-1:0] rdata_o;
  logic          busy_o;
  logic          mem_en_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [LW-1:0] mem_wdata_o;
  logic [LW-1:0] mem_rdata_i;

  modport slave (
    input  wcyc_i, rcyc_i, waddr_i, raddr_i, wdata_i, mem_rdata_i,
    output ack_o, rdata_o, busy_o, mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output wcyc_i, rcyc_i, waddr_i, raddr_i, wdata_i, mem_rdata_i,
    input  ack_o, rdata_o, busy_o, mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/main_mem_ctrl.sv
// Main-memory line controller: serialises an optional write-back and an optional
// refill into fixed-latency memory accesses and returns a single ack per request.
module main_mem_ctrl
  import param_pkg::*;
#(
  parameter int WR_LAT = 2,
  parameter int RD_LAT = 3
) (
  input logic            clk,
  input logic            resetn,
  main_mem_ctrl_if.slave bus
);
  localparam int LW = BYTES_PER_LINE * 8;
  localparam int AW = MAIN_MEM_LINE_AW;

  if (WR_LAT < 1 || WR_LAT > 15) begin : g_wr_lat_chk
    $error("main_mem_ctrl: WR_LAT must be in 1..15");
  end
  if (RD_LAT < 1 || RD_LAT > 15) begin : g_rd_lat_chk
    $error("main_mem_ctrl: RD_LAT must be in 1..15");
  end

  // Counter runs 0..TC inside a state; WR spans WR_LAT cycles, RD spans RD_LAT+1.
  localparam logic [3:0] WR_TC = 4'(WR_LAT - 1);
  localparam logic [3:0] RD_TC = 4'(RD_LAT);

  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_ACK, S_GAP} state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          wcyc_q, wcyc_d;
  logic          rcyc_q, rcyc_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [AW-1:0] raddr_q, raddr_d;
  logic [LW-1:0] wdata_q, wdata_d;
  logic [LW-1:0] rdata_q, rdata_d;

  logic          ack;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [LW-1:0] mem_wdata;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wcyc_q  <= 1'b0;
      rcyc_q  <= 1'b0;
      waddr_q <= '0;
      raddr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wcyc_q  <= wcyc_d;
      rcyc_q  <= rcyc_d;
      waddr_q <= waddr_d;
      raddr_q <= raddr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wcyc_d    = wcyc_q;
    rcyc_d    = rcyc_q;
    waddr_d   = waddr_q;
    raddr_d   = raddr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    ack       = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.wcyc_i || bus.rcyc_i) begin
          wcyc_d  = bus.wcyc_i;
          rcyc_d  = bus.rcyc_i;
          waddr_d = bus.waddr_i;
          raddr_d = bus.raddr_i;
          wdata_d = bus.wdata_i;
          cnt_d   = '0;
          state_d = bus.wcyc_i ? S_WR : S_RD;
        end
      end
      S_WR: begin
        if (cnt_q == 4'd0) begin
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = waddr_q;
          mem_wdata = wdata_q;
        end
        if (cnt_q == WR_TC) begin
          cnt_d   = '0;
          state_d = rcyc_q ? S_RD : S_ACK;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_RD: begin
        if (cnt_q == 4'd0) begin
          mem_en   = 1'b1;
          mem_addr = raddr_q;
        end
        // Memory data is valid exactly in the terminal cycle; latch it there.
        if (cnt_q == RD_TC) begin
          rdata_d = bus.mem_rdata_i;
          cnt_d   = '0;
          state_d = S_ACK;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_ACK: begin
        ack     = 1'b1;
        state_d = S_GAP;
      end
      // One dead cycle so a grant still high after ack is not serviced twice.
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.ack_o       = ack;
  assign bus.rdata_o     = rdata_q;
  assign bus.busy_o      = (state_q != S_IDLE);
  assign bus.mem_en_o    = mem_en;
  assign bus.mem_we_o    = mem_we;
  assign bus.mem_addr_o  = mem_addr;
  assign bus.mem_wdata_o = mem_wdata;
endmodule

// File: tb/tb_main_mem_ctrl.sv
// Scoreboard bench for main_mem_ctrl: expected memory strobes and acks are
// queued when a request is driven and checked when the DUT produces them.
module tb_main_mem_ctrl;
  localparam int LW     = param_pkg::BYTES_PER_LINE * 8;
  localparam int AW     = param_pkg::MAIN_MEM_LINE_AW;
  localparam int WR_LAT = 2;
  localparam int RD_LAT = 3;

  typedef struct { int cyc; logic we; logic [AW-1:0] addr; logic [LW-1:0] wdata; } mem_exp_t;
  typedef struct { int cyc; logic [LW-1:0] rdata; } ack_exp_t;
  typedef struct { int due; logic [LW-1:0] data; } rd_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   acks_seen = 0;

  mem_exp_t mq[$];
  ack_exp_t aq[$];
  rd_t      rdq[$];
  logic [LW-1:0] mem     [0:(1<<AW)-1];
  logic [LW-1:0] ref_mem [0:(1<<AW)-1];
  logic [LW-1:0] exp_rd = '0;

  main_mem_ctrl_if #(.LW(LW), .AW(AW)) b ();

  main_mem_ctrl #(.WR_LAT(WR_LAT), .RD_LAT(RD_LAT)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (b.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // Memory model plus output monitor, sampled mid-cycle.
  always @(negedge clk) begin
    mem_exp_t e;
    if (rdq.size() > 0 && rdq[0].due == cyc) begin
      b.mem_rdata_i = rdq[0].data;
      void'(rdq.pop_front());
    end else begin
      b.mem_rdata_i = {$urandom, $urandom, $urandom, $urandom};
    end
    if (resetn) begin
      if (b.mem_en_o) begin
        if (mq.size() == 0) chk("mem_en_unexpected", 1, 0);
        else begin
          e = mq.pop_front();
          chk("mem_cyc", cyc, e.cyc);
          chk("mem_we", b.mem_we_o, e.we);
          chk("mem_addr", b.mem_addr_o, e.addr);
          if (e.we) chk("mem_wdata", b.mem_wdata_o, e.wdata);
        end
        if (b.mem_we_o) mem[b.mem_addr_o] = b.mem_wdata_o;
        else rdq.push_back('{cyc + RD_LAT, mem[b.mem_addr_o]});
      end else begin
        chk("mem_idle_zero", LW'({b.mem_we_o, b.mem_addr_o} | (b.mem_wdata_o != '0)), 0);
      end
      if (b.ack_o) begin
        acks_seen++;
        if (aq.size() == 0) chk("ack_unexpected", 1, 0);
        else begin
          chk("ack_cyc", cyc, aq[0].cyc);
          chk("ack_rdata", b.rdata_o, aq[0].rdata);
          void'(aq.pop_front());
        end
      end
    end
  end

  task automatic push_exp(input int t, input logic w, input logic r,
                          input logic [AW-1:0] wa, input logic [AW-1:0] ra,
                          input logic [LW-1:0] wd);
    int ac;
    if (w) begin
      mq.push_back('{t + 1, 1'b1, wa, wd});
      ref_mem[wa] = wd;
    end
    if (r) begin
      mq.push_back('{(w ? t + WR_LAT + 1 : t + 1), 1'b0, ra, '0});
      exp_rd = ref_mem[ra];
    end
    ac = (w && r) ? t + WR_LAT + RD_LAT + 2 : (w ? t + WR_LAT + 1 : t + RD_LAT + 2);
    aq.push_back('{ac, exp_rd});
  endtask

  task automatic wait_idle();
    int k = 0;
    @(negedge clk);
    while (b.busy_o && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (b.busy_o) chk("idle_timeout", 0, 1);
  endtask

  task automatic wait_acks(input int n);
    int tgt = acks_seen + n;
    int k = 0;
    while (acks_seen < tgt && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (acks_seen < tgt) chk("ack_timeout", 0, 1);
  endtask

  // Drive one request for one cycle, then scramble the inputs while busy.
  task automatic txn(input logic w, input logic r, input logic [AW-1:0] wa,
                     input logic [AW-1:0] ra, input logic [LW-1:0] wd);
    int t;
    wait_idle();
    b.wcyc_i = w; b.rcyc_i = r; b.waddr_i = wa; b.raddr_i = ra; b.wdata_i = wd;
    t = cyc;
    push_exp(t, w, r, wa, ra, wd);
    @(negedge clk);
    chk("busy", b.busy_o, 1);
    b.wcyc_i = 1'b0; b.rcyc_i = 1'b0;
    b.waddr_i = wa ^ AW'('h14); b.raddr_i = ra ^ AW'(1); b.wdata_i = ~wd;
    wait_acks(1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ack"}, b.ack_o, 0);
    chk({tag, "_busy"}, b.busy_o, 0);
    chk({tag, "_en"}, b.mem_en_o, 0);
    chk({tag, "_we"}, b.mem_we_o, 0);
    chk({tag, "_addr"}, b.mem_addr_o, 0);
    chk({tag, "_wdata"}, b.mem_wdata_o, 0);
    chk({tag, "_rdata"}, b.rdata_o, 0);
  endtask

  initial begin
    int t;
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i]     = {4{32'(i) * 32'h9E37_79B9}};
      ref_mem[i] = mem[i];
    end
    mem[10'h3FF] = LW'('h1234);
    ref_mem[10'h3FF] = LW'('h1234);
    b.wcyc_i = 1'b0; b.rcyc_i = 1'b0; b.waddr_i = '0; b.raddr_i = '0; b.wdata_i = '0;
    b.mem_rdata_i = '0;

    #22;
    chk_all_zero("reset");
    @(negedge clk);
    resetn = 1'b1;

    txn(1'b1, 1'b0, AW'('h05), AW'('h00), {16{8'hA5}});
    txn(1'b0, 1'b1, AW'('h00), AW'('h3FF), '0);
    txn(1'b1, 1'b1, AW'('h10), AW'('h20), {4{32'hDEAD_BEEF}});
    txn(1'b1, 1'b1, AW'('h21), AW'('h21), {4{32'h0BAD_F00D}});

    // Grant held through ack: the second capture happens two cycles after ack.
    wait_idle();
    b.wcyc_i = 1'b1; b.rcyc_i = 1'b0; b.waddr_i = AW'('h33); b.wdata_i = {4{32'h5555_AAAA}};
    t = cyc;
    push_exp(t, 1'b1, 1'b0, AW'('h33), '0, {4{32'h5555_AAAA}});
    push_exp(t + WR_LAT + 3, 1'b1, 1'b0, AW'('h33), '0, {4{32'h5555_AAAA}});
    while (cyc < t + WR_LAT + 4) @(negedge clk);
    b.wcyc_i = 1'b0;
    wait_acks(1);

    // Reset during a read: everything drops at once and the ack never comes.
    wait_idle();
    b.rcyc_i = 1'b1; b.raddr_i = AW'('h3FF);
    t = cyc;
    push_exp(t, 1'b0, 1'b1, '0, AW'('h3FF), '0);
    @(negedge clk);
    b.rcyc_i = 1'b0;
    @(posedge clk);
    #2 resetn = 1'b0;
    #1 chk_all_zero("midrst");
    aq.delete(); rdq.delete();
    chk("midrst_mq_drained", LW'(mq.size()), 0);
    mq.delete();
    exp_rd = '0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    txn(1'b0, 1'b1, '0, AW'('h3FF), '0);

    for (int i = 0; i < 20; i++) begin
      logic [1:0] k;
      k = 2'($urandom_range(1, 3));
      txn(k[0], k[1], AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
          {$urandom, $urandom, $urandom, $urandom});
    end

    repeat (12) @(negedge clk);
    chk("end_mq_empty", LW'(mq.size()), 0);
    chk("end_aq_empty", LW'(aq.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/main_mem_ctrl.md
MAIN_MEM_CTRL -- requirements
Module: main_mem_ctrl

Interface
REQ-001 SHALL take BYTES_PER_LINE and MAIN_MEM_LINE_AW from param_pkg; LW = BYTES_PER_LINE*8.
REQ-002 SHALL have parameter WR_LAT, default 2, write occupancy cycles (legal 1..15).
REQ-003 SHALL have parameter RD_LAT, default 3, cycles from read issue to mem_rdata_i valid (legal 1..15).
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 resetn  in  1  reset, asynchronous, active-low.
REQ-006 wcyc_i  in  1  granted master requests line write (write-back).
REQ-007 rcyc_i  in  1  granted master requests line read (refill).
REQ-008 waddr_i  in  MAIN_MEM_LINE_AW  write line address.
REQ-009 raddr_i  in  MAIN_MEM_LINE_AW  read line address.
REQ-010 wdata_i  in  LW  write line data.
REQ-011 ack_o  out  1  one-cycle completion pulse to the main-memory arbiter ack_i.
REQ-012 rdata_o  out  LW  registered read line.
REQ-013 busy_o  out  1  high in every state except IDLE.
REQ-014 mem_en_o  out  1  memory access strobe, one cycle per access.
REQ-015 mem_we_o  out  1  write enable, qualified by mem_en_o.
REQ-016 mem_addr_o  out  MAIN_MEM_LINE_AW  memory line address.
REQ-017 mem_wdata_o  out  LW  memory write data.
REQ-018 mem_rdata_i  in  LW  memory read data, valid exactly RD_LAT cycles after read issue.

Function
REQ-019 SHALL implement FSM states IDLE, WR, RD, ACK, GAP.
REQ-020 In IDLE, if wcyc_i|rcyc_i, SHALL capture waddr_i, raddr_i, wdata_i, wcyc_i, rcyc_i into internal registers; go to WR if wcyc_i else RD.
REQ-021 All request inputs SHALL be ignored outside IDLE; captured values drive the transaction.
REQ-022 WR SHALL last exactly WR_LAT cycles: first cycle mem_en_o=1, mem_we_o=1, mem_addr_o=captured waddr, mem_wdata_o=captured wdata; remaining cycles mem_en_o=0.
REQ-023 On leaving WR, SHALL go to RD if captured rcyc=1, else ACK (write precedes read when both set).
REQ-024 RD SHALL last RD_LAT+1 cycles: first cycle mem_en_o=1, mem_we_o=0, mem_addr_o=captured raddr; in last cycle SHALL register mem_rdata_i into rdata_o; then go to ACK.
REQ-025 ACK SHALL last one cycle with ack_o=1; exactly one ack_o per transaction, including combined write+read.
REQ-026 GAP SHALL last one cycle ignoring inputs, then go to IDLE, so a grant still held by the arbiter in the cycle after ack_o is never re-serviced.
REQ-027 Latency from IDLE capture cycle T to ack_o: write-only T+WR_LAT+1; read-only T+RD_LAT+2; write+read T+WR_LAT+RD_LAT+2.
REQ-028 rdata_o SHALL hold its value until the next read completes; write-only transactions SHALL not modify it.
REQ-029 mem_addr_o, mem_wdata_o, mem_we_o SHALL be 0 whenever mem_en_o=0.
REQ-030 Wait counter SHALL be 4 bits, loaded on state entry, compared to terminal count; no wrap-around possible within legal parameters.
REQ-031 Out-of-range WR_LAT/RD_LAT SHALL trigger an elaboration-time error.

Reset
REQ-032 resetn low SHALL asynchronously force IDLE, ack_o=0, busy_o=0, mem_en_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, rdata_o=0, captured registers=0.
REQ-033 Reset mid-transaction SHALL abort it with no ack_o; first capture is possible in the first IDLE cycle after release.

Verification (WR_LAT=2, RD_LAT=3, BYTES_PER_LINE=16, MAIN_MEM_LINE_AW=10)
REQ-034 Write-only: wcyc_i=1, waddr_i=0x05, wdata_i=0xA5..A5 at T -> mem_en_o/mem_we_o=1, mem_addr_o=0x05 at T+1; ack_o at T+3 only; rdata_o unchanged.
REQ-035 Read-only: rcyc_i=1, raddr_i=0x3FF at T, memory model returns 0x1234 at T+4 -> mem_en_o=1, mem_we_o=0 at T+1; ack_o at T+5 with rdata_o=0x1234.
REQ-036 Combined: wcyc_i=rcyc_i=1, waddr_i=0x10, raddr_i=0x20 at T -> write issue T+1, read issue T+3, single ack_o at T+7.
REQ-037 Held grant: request held asserted through ack_o -> no second mem_en_o during GAP; new capture no earlier than ack_o cycle +2.
REQ-038 Reset mid-read: resetn low at T+2 of a read -> all outputs 0 immediately, no ack_o; next request after release completes normally.
REQ-039 Input change: waddr_i changed to 0x11 at T+1 of REQ-034 -> mem_addr_o stays 0x05.
